// File: rtl/shift_pkg.sv
// Shared types and constants for the shift unit and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

  // ALU operation encoding; only the three shift codes are legal here.
  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_SLL = 4'd2;
  localparam alu_op_t OP_SRL = 4'd6;
  localparam alu_op_t OP_SRA = 4'd7;

  // Shift amount is always the low 5 bits of operand B.
  localparam int SHAMT_W = 5;

  // Output buffer occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared shifter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on each request lane and on the response channel.
// Ports: req_valid/req_ready/req_a/req_b/req_op/req_tag (per requester, packed
//        slice i = requester i), rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_tag/
//        rsp_illegal (single response channel).
interface shift_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*4-1:0]      req_op;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_illegal;

  // Requesters plus response consumer.
  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_illegal
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_illegal
  );

endinterface

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: SLL / SRL / SRA, anything else flagged illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
// Ports: a, b (amount = b[4:0]), op in; result, illegal out.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  logic [SHAMT_W-1:0] shamt;
  logic               unused_b_hi;

  assign shamt       = b[SHAMT_W-1:0];
  // Upper bits of B carry no meaning for a shift.
  assign unused_b_hi = ^b[DATA_W-1:SHAMT_W];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shares one shift_core among NUM_REQ requesters, result buffered.
// Latency: request accepted in cycle N is presented as rsp_valid in cycle N+1.
// Backpressure: rsp_ready=0 with a full buffer holds rsp_* and blocks all grants.
// Ports: clk, rst_n (async active-low), bus (shift_arbiter_if.slave).
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  buf_state_t        state, state_next;
  logic [ID_W-1:0]   ptr, winner, idx;
  logic              found, can_accept, grant;
  logic [NUM_REQ-1:0] ready_vec;

  logic [DATA_W-1:0] a_sel, b_sel, core_res;
  alu_op_t           op_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic              core_illegal;

  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;
  logic [TAG_W-1:0]  tag_q;
  logic              illegal_q;

  // Rotating priority scan: first valid requester at or above ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Operand mux onto the shared datapath.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    op_sel  = '0;
    tag_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel   = bus.req_a[i*DATA_W +: DATA_W];
        b_sel   = bus.req_b[i*DATA_W +: DATA_W];
        op_sel  = bus.req_op[i*4 +: 4];
        tag_sel = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  shift_core #(.DATA_W(DATA_W)) u_core (
    .a       (a_sel),
    .b       (b_sel),
    .op      (op_sel),
    .result  (core_res),
    .illegal (core_illegal)
  );

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // FSM: next state.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (bus.rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // FSM: outputs. A full buffer can take a new result only if it drains now.
  always_comb begin
    can_accept    = (state == EMPTY) || bus.rsp_ready;
    grant         = can_accept && found;
    bus.rsp_valid = (state == FULL);
  end

  // Ready goes to the winner only; forced low while reset is asserted.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_vec[i] = rst_n && grant && (winner == ID_W'(i));
    end
  end
  assign bus.req_ready = ready_vec;

  // Pointer moves past the winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Output buffer; reload on grant covers the simultaneous drain case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      id_q      <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
    end else if (grant) begin
      data_q    <= core_res;
      id_q      <= winner;
      tag_q     <= tag_sel;
      illegal_q <= core_illegal;
    end
  end

  assign bus.rsp_data    = data_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_illegal = illegal_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  shift_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [3:0] tag);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_op[i*4 +: 4]          = op;
    bus.req_tag[i*TAG_W +: TAG_W] = tag;
    bus.req_valid[i]              = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    set_req(0, 32'h1, 32'h1, 4'd2, 4'h1);
    set_req(1, 32'h1, 32'h1, 4'd2, 4'h2);
    #12;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%h want=0", bus.rsp_id); end
    total++; if (bus.rsp_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%h want=0", bus.rsp_tag); end
    total++; if (bus.rsp_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.rsp_illegal); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", bus.req_ready); end
    #1;
    bus.req_valid = '0;
    rst_n         = 1'b1;
    tick();
  endtask

  task automatic test_sll();
    set_req(0, 32'h0000_0001, 32'd31, 4'd2, 4'h5);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL sll_ready got=%b want=01", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL sll_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h8000_0000) begin bad++; $display("FAIL sll_data got=%h want=80000000", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL sll_id got=%h want=0", bus.rsp_id); end
    total++; if (bus.rsp_tag !== 4'h5) begin bad++; $display("FAIL sll_tag got=%h want=5", bus.rsp_tag); end
    total++; if (bus.rsp_illegal !== 1'b0) begin bad++; $display("FAIL sll_illegal got=%b want=0", bus.rsp_illegal); end
  endtask

  task automatic test_srl_sra();
    set_req(1, 32'h8000_0000, 32'h0000_0024, 4'd6, 4'h1);
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL srl_ready got=%b want=10", bus.req_ready); end
    tick();
    total++; if (bus.rsp_data !== 32'h0800_0000) begin bad++; $display("FAIL srl_data got=%h want=08000000", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL srl_id got=%h want=1", bus.rsp_id); end
    total++; if (bus.rsp_tag !== 4'h1) begin bad++; $display("FAIL srl_tag got=%h want=1", bus.rsp_tag); end
    set_req(1, 32'h8000_0000, 32'h0000_0024, 4'd7, 4'h2);
    tick();
    bus.req_valid = '0;
    total++; if (bus.rsp_data !== 32'hF800_0000) begin bad++; $display("FAIL sra_data got=%h want=f8000000", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL sra_id got=%h want=1", bus.rsp_id); end
    total++; if (bus.rsp_tag !== 4'h2) begin bad++; $display("FAIL sra_tag got=%h want=2", bus.rsp_tag); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL sra_drain got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [0:0]  exp_id  [4];
    logic [3:0]  exp_tag [4];
    logic [31:0] exp_dat [4];
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_tag = '{4'hA, 4'hB, 4'hA, 4'hB};
    exp_dat = '{32'h10, 32'h100, 32'h10, 32'h100};
    set_req(0, 32'h1, 32'd4, 4'd2, 4'hA);
    set_req(1, 32'h1, 32'd8, 4'd2, 4'hB);
    for (int n = 0; n < 4; n++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", n, bus.rsp_valid); end
      total++; if (bus.rsp_id !== exp_id[n]) begin bad++; $display("FAIL b2b_id[%0d] got=%h want=%h", n, bus.rsp_id, exp_id[n]); end
      total++; if (bus.rsp_tag !== exp_tag[n]) begin bad++; $display("FAIL b2b_tag[%0d] got=%h want=%h", n, bus.rsp_tag, exp_tag[n]); end
      total++; if (bus.rsp_data !== exp_dat[n]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", n, bus.rsp_data, exp_dat[n]); end
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL stall_ready0 got=%b want=00", bus.req_ready); end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_tag !== 4'hB || bus.rsp_data !== 32'h100)
        begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%h want=1/1/b/00000100", n, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=00", n, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL release_ready got=%b want=01", bus.req_ready); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_tag !== 4'hA || bus.rsp_data !== 32'h10)
      begin bad++; $display("FAIL release_rsp got=%b/%h/%h/%h want=1/0/a/00000010", bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data); end
    bus.req_valid = '0;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL release_drain got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_illegal();
    set_req(1, 32'hFFFF_FFFF, 32'd3, 4'd3, 4'h7);
    tick();
    bus.req_valid = '0;
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL ill_data got=%h want=0", bus.rsp_data); end
    total++; if (bus.rsp_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", bus.rsp_illegal); end
    total++; if (bus.rsp_id !== 1'b1 || bus.rsp_tag !== 4'h7) begin bad++; $display("FAIL ill_idtag got=%h/%h want=1/7", bus.rsp_id, bus.rsp_tag); end
    set_req(0, 32'h1, 32'd0, 4'd2, 4'h3);
    set_req(1, 32'h2, 32'd0, 4'd2, 4'h4);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL ill_ptr_ready got=%b want=01", bus.req_ready); end
    tick();
    total++; if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h1 || bus.rsp_illegal !== 1'b0)
      begin bad++; $display("FAIL ill_next got=%h/%h/%b want=0/00000001/0", bus.rsp_id, bus.rsp_data, bus.rsp_illegal); end
  endtask

  task automatic test_mid_reset();
    // Buffer is FULL (id 0) and the pointer sits at 1 here.
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL mrst_data got=%h want=0", bus.rsp_data); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL mrst_ready got=%b want=00", bus.req_ready); end
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mrst_ptr got=%b want=01", bus.req_ready); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_tag !== 4'h3)
      begin bad++; $display("FAIL mrst_first got=%b/%h/%h want=1/0/3", bus.rsp_valid, bus.rsp_id, bus.rsp_tag); end
    bus.req_valid = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sll();
    test_srl_sra();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_mid_reset();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational 32-bit shift datapath (SLL/SRL/SRA) between NUM_REQ independent requesters, such as integer pipeline lanes or a multi-cycle sequencer.
- Arbitration is round-robin, with valid/ready request channels.
- The result is registered in a single-entry output buffer.
- Results leave on one response channel, tagged with requester ID and a requester-supplied tag.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width; shift amount is always B[4:0]
TAG_W, 4, opaque requester tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  in  NUM_REQ*DATA_W  operand A, requester i at slice i
req_b  in  NUM_REQ*DATA_W  operand B (shift amount = B[4:0])
req_op  in  NUM_REQ*4  ALU_op: 4'd2 SLL, 4'd6 SRL, 4'd7 SRA
req_tag  in  NUM_REQ*TAG_W  opaque tag, returned unchanged
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  DATA_W  shift result
rsp_id  out  $clog2(NUM_REQ)  index of the requester served
rsp_tag  out  TAG_W  tag of the served request
rsp_illegal  out  1  op was not 2/6/7; rsp_data is 0

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, rsp_illegal=0.
  - Internal: round-robin pointer=0, state=EMPTY.
  - req_ready is forced 0 while rst_n=0.
- State machine on the output buffer: EMPTY, FULL.
  - EMPTY: a grant loads the buffer -> FULL.
  - FULL with rsp_ready=1 and a new grant: reload the buffer, stay FULL (back-to-back, 1 result/cycle).
  - FULL with rsp_ready=1 and no grant -> EMPTY.
  - FULL with rsp_ready=0: hold all rsp_* stable; no grants.
- Accept condition: can_accept = (state==EMPTY) | rsp_ready.
- req_ready[i] is 1 only for the winner i, only when can_accept, and is combinational from req_valid, the pointer, state and rsp_ready. A handshake is req_valid[i] & req_ready[i].
- Round-robin arbitration:
  - Scan from the pointer upward, wrapping modulo NUM_REQ; the first valid requester wins.
  - After a grant, pointer = winner+1 (wraps NUM_REQ-1 -> 0).
  - Without a grant, the pointer is unchanged.
  - No requester may wait more than NUM_REQ-1 grants.
- Latency: a request accepted in cycle N has rsp_valid=1 in cycle N+1.
- Datapath:
  - Operates on the winner's A, B, op in the grant cycle.
  - SLL: A << B[4:0]. SRL: A >> B[4:0] with zero fill. SRA: arithmetic, A[31] fill.
  - B[31:5] is ignored; amount 0 passes A unchanged.
  - Any other op: result 0, rsp_illegal=1; the request is still consumed and arbitrated normally.
- Requester obligations: req_a/b/op/tag stay stable while req_valid=1 and not yet accepted. A requester may drop req_valid before acceptance; that is legal and simply forfeits arbitration.
- Simultaneous drain and accept: the buffer is overwritten in the same edge; no bubble, no loss.
- Reset mid-operation: the buffered response is discarded and no response is emitted for it.

Decomposition:
- Package shift_pkg holds:
  - alu_op_t (4-bit), with constants OP_SLL=4'd2, OP_SRL=4'd6, OP_SRA=4'd7.
  - SHAMT_W=5.
  - buf_state_t enum {EMPTY, FULL}.
- One sub-module, shift_core: pure combinational (A, B, op) -> (result, illegal), shared by this block and any other user of the shift unit.
- Arbiter and output buffer stay in shift_arbiter.

Test Plan:
- Req0 only: A=0x00000001, B=31, op=2 -> next cycle rsp_valid=1, rsp_data=0x80000000, rsp_id=0, rsp_illegal=0.
- Req1 only, SRL vs SRA on A=0x80000000, B=0x24 (amount 4):
  - op=6 -> 0x08000000.
  - op=7 -> 0xF8000000.
  - Confirms B[31:5] is ignored.
- Both valid continuously, rsp_ready=1:
  - Grants alternate 0,1,0,1 with one response per cycle.
  - rsp_tag matches the sender each time.
- rsp_ready=0 for 3 cycles while FULL:
  - rsp_* stay stable and req_ready stays 0 throughout.
  - On release the next grant lands in the same cycle as the drain.
- Illegal op=4'd3, A=0xFFFFFFFF -> rsp_data=0, rsp_illegal=1; the round-robin pointer still advances.
- Assert rst_n=0 while FULL -> rsp_valid drops immediately (async); after release the first grant goes to requester 0.
